// File: rtl/trig_pkg.sv
// trig_pkg: shared types, defaults and helpers for the external trigger conditioner.
// Contents:
//   state_t   - conditioner FSM states (IDLE/DELAY/FIRE/HOLDOFF)
//   CNT_W_DEF - default width of the accepted/dropped event counters
//   sat_inc   - saturating increment against a caller-supplied all-ones value
package trig_pkg;

   typedef enum logic [1:0] {IDLE, DELAY, FIRE, HOLDOFF} state_t;

   localparam int CNT_W_DEF = 32;

   // Counters narrower than 64 bits pass their own all-ones value as max_v.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
      return (v == max_v) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/trig_in_glitch_filter.sv
// trig_in_glitch_filter: synchronises the external trigger, applies polarity,
// rejects glitches and emits a one-cycle candidate per filtered rising edge.
// Ports:
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   trig_ext_i          - raw external trigger pin (asynchronous)
//   reg_trig_in_polar   - 1 inverts the synchronised level
//   reg_filter_width    - W: level must differ from filt for W+1 samples
//   cand_o              - one-cycle pulse on each filtered rising edge
module trig_in_glitch_filter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        trig_ext_i,
   input  logic        reg_trig_in_polar,
   input  logic [15:0] reg_filter_width,
   output logic        cand_o
);

   logic        r_s1, r_s2, r_filt, r_filt_d;
   logic [15:0] r_stab;
   logic        w_lvl;

   assign w_lvl  = r_s2 ^ reg_trig_in_polar;
   assign cand_o = r_filt & ~r_filt_d;

   // r_stab counts consecutive samples that disagree with r_filt; >= keeps a
   // shrinking width from letting the count run past the compare point.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_filt   <= 1'b0;
         r_filt_d <= 1'b0;
         r_stab   <= '0;
      end else begin
         r_s1     <= trig_ext_i;
         r_s2     <= r_s1;
         r_filt_d <= r_filt;
         r_filt   <= (w_lvl != r_filt && r_stab >= reg_filter_width) ? w_lvl : r_filt;
         r_stab   <= (w_lvl == r_filt || r_stab >= reg_filter_width) ? '0 : r_stab + 16'd1;
      end
   end

endmodule

// File: rtl/trig_in_cond.sv
// trig_in_cond: external trigger receive conditioner - filter, N-th edge divider,
// optional delay, re-arm holdoff, single-cycle trigger pulse and event counters.
// Build option: define TRIG_IN_DELAY_EN to build the DELAY state and honour reg_delay;
// otherwise reg_delay is ignored and latency is fixed at 3+W.
// Ports:
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   trig_ext_i          - raw external trigger pin (asynchronous)
//   reg_trig_in_polar   - input polarity (1 = active-low)
//   reg_filter_width    - glitch filter width W
//   reg_div             - accept one candidate of max(reg_div,1)
//   reg_delay           - D cycles from acceptance to pulse
//   reg_holdoff         - H re-arm cycles after the pulse
//   reg_cnt_clr         - level clear of both counters
//   busy_i              - downstream busy; candidates dropped while high
//   trigger_o           - one-cycle trigger pulse
//   busy_o              - FSM not in IDLE
//   trig_cnt_o          - saturating count of issued pulses
//   drop_cnt_o          - saturating count of dropped candidates
module trig_in_cond
   import trig_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             trig_ext_i,
   input  logic             reg_trig_in_polar,
   input  logic [15:0]      reg_filter_width,
   input  logic [7:0]       reg_div,
   input  logic [31:0]      reg_delay,
   input  logic [31:0]      reg_holdoff,
   input  logic             reg_cnt_clr,
   input  logic             busy_i,
   output logic             trigger_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] trig_cnt_o,
   output logic [CNT_W-1:0] drop_cnt_o
);

   state_t           r_state, w_next;
   logic [7:0]       r_div_cnt, w_div_max;
   logic [31:0]      r_cnt, r_hold, w_cnt_nxt;
   logic [CNT_W-1:0] r_trig_cnt, r_drop_cnt, w_ones;
   logic             w_cand, w_open, w_accept, w_drop;

   trig_in_glitch_filter u_filter (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .trig_ext_i        (trig_ext_i),
      .reg_trig_in_polar (reg_trig_in_polar),
      .reg_filter_width  (reg_filter_width),
      .cand_o            (w_cand)
   );

   // Only candidates arriving in IDLE with the sequencer free reach the divider.
   assign w_open    = (r_state == IDLE) & ~busy_i;
   assign w_accept  = w_cand & w_open & (r_div_cnt == 8'd0);
   assign w_drop    = w_cand & ~w_open;
   assign w_div_max = (reg_div == 8'd0) ? 8'd0 : reg_div - 8'd1;
   assign w_ones    = '1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
`ifdef TRIG_IN_DELAY_EN
         IDLE:    w_next = w_accept ? ((reg_delay != 32'd0) ? DELAY : FIRE) : IDLE;
         DELAY:   w_next = (r_cnt == 32'd1) ? FIRE : DELAY;
`else
         IDLE:    w_next = w_accept ? FIRE : IDLE;
`endif
         FIRE:    w_next = (r_hold != 32'd0) ? HOLDOFF : IDLE;
         HOLDOFF: w_next = (r_cnt == 32'd1) ? IDLE : HOLDOFF;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      trigger_o = (r_state == FIRE);
      busy_o    = (r_state != IDLE);
   end

   // One down-counter serves DELAY (loaded with D on accept) and HOLDOFF
   // (loaded with the latched H in FIRE); both states exit when it reads 1.
`ifdef TRIG_IN_DELAY_EN
   assign w_cnt_nxt = w_accept ? reg_delay :
                      (r_state == FIRE) ? r_hold :
                      (r_cnt != 32'd0) ? r_cnt - 32'd1 : r_cnt;
`else
   logic w_unused_delay;
   assign w_unused_delay = ^reg_delay;
   assign w_cnt_nxt = (r_state == FIRE) ? r_hold :
                      (r_cnt != 32'd0) ? r_cnt - 32'd1 : r_cnt;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_hold     <= '0;
         r_div_cnt  <= '0;
         r_trig_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_hold     <= w_accept ? reg_holdoff : r_hold;
         r_div_cnt  <= (w_cand & w_open) ? ((r_div_cnt >= w_div_max) ? 8'd0 : r_div_cnt + 8'd1) : r_div_cnt;
         r_trig_cnt <= reg_cnt_clr ? '0 :
                       (r_state == FIRE) ? CNT_W'(sat_inc(64'(r_trig_cnt), 64'(w_ones))) : r_trig_cnt;
         r_drop_cnt <= reg_cnt_clr ? '0 :
                       w_drop ? CNT_W'(sat_inc(64'(r_drop_cnt), 64'(w_ones))) : r_drop_cnt;
      end
   end

   assign trig_cnt_o = r_trig_cnt;
   assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_trig_in_cond.sv
// tb_trig_in_cond: scoreboard bench for trig_in_cond; expected pulse cycles are
// queued when a trigger edge is driven and matched when trigger_o is seen.
module tb_trig_in_cond;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        trig_ext_i = 1'b0;
   logic        reg_trig_in_polar = 1'b0;
   logic [15:0] reg_filter_width = '0;
   logic [7:0]  reg_div = 8'd1;
   logic [31:0] reg_delay = '0;
   logic [31:0] reg_holdoff = '0;
   logic        reg_cnt_clr = 1'b0;
   logic        busy_i = 1'b0;
   logic        trigger_o, busy_o;
   logic [31:0] trig_cnt_o, drop_cnt_o;

`ifdef TRIG_IN_DELAY_EN
   localparam bit DLY = 1'b1;
`else
   localparam bit DLY = 1'b0;
`endif

   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;
   int unsigned exp_q[$];

   trig_in_cond dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .trig_ext_i        (trig_ext_i),
      .reg_trig_in_polar (reg_trig_in_polar),
      .reg_filter_width  (reg_filter_width),
      .reg_div           (reg_div),
      .reg_delay         (reg_delay),
      .reg_holdoff       (reg_holdoff),
      .reg_cnt_clr       (reg_cnt_clr),
      .busy_i            (busy_i),
      .trigger_o         (trigger_o),
      .busy_o            (busy_o),
      .trig_cnt_o        (trig_cnt_o),
      .drop_cnt_o        (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (trigger_o === 1'b1) begin
         if (exp_q.size() == 0)
            chk("spurious_pulse", 64'd1, 64'd0);
         else
            chk("pulse_cycle", 64'(cyc), 64'(exp_q.pop_front()));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // Expected pulse: first sampling edge is cyc+1, pulse follows edge 3+W+D.
   task automatic push_exp();
      exp_q.push_back(cyc + 1 + 3 + 32'(reg_filter_width) + (DLY ? reg_delay : 32'd0));
   endtask

   task automatic pulse(input int len, input bit acc);
      trig_ext_i = 1'b1;
      if (acc) push_exp();
      tick(len);
      trig_ext_i = 1'b0;
   endtask

   task automatic clr();
      reg_cnt_clr = 1'b1;
      tick(1);
      reg_cnt_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick(3);
      chk("rst_trigger", trigger_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_trig_cnt", trig_cnt_o, 0);
      chk("rst_drop_cnt", drop_cnt_o, 0);
      rst_i = 1'b0;
      tick(3);

      // clean pulse, W=0 D=0 H=0
      pulse(10, 1);
      tick(20);
      chk("t1_pend", exp_q.size(), 0);
      chk("t1_trig_cnt", trig_cnt_o, 1);
      chk("t1_drop_cnt", drop_cnt_o, 0);

      // glitch rejection with W=4
      reg_filter_width = 16'd4;
      pulse(3, 0);
      tick(20);
      pulse(6, 1);
      tick(20);
      chk("t2_pend", exp_q.size(), 0);
      chk("t2_trig_cnt", trig_cnt_o, 2);

      // delay + holdoff, second edge dropped, third accepted
      reg_filter_width = 16'd0;
      reg_delay = 32'd100;
      reg_holdoff = 32'd50;
      pulse(5, 1);
      tick(35);
      pulse(5, 0);
      chk("t3_busy", busy_o, 1);
      tick(200);
      chk("t3_idle", busy_o, 0);
      pulse(5, 1);
      tick(200);
      chk("t3_pend", exp_q.size(), 0);
      chk("t3_trig_cnt", trig_cnt_o, 4);
      chk("t3_drop_cnt", drop_cnt_o, 1);

      // divide by 3
      reg_delay = 32'd0;
      reg_holdoff = 32'd0;
      clr();
      chk("t4_clr_trig", trig_cnt_o, 0);
      reg_div = 8'd3;
      for (int i = 0; i < 9; i++) begin
         pulse(5, (i % 3) == 0);
         tick(15);
      end
      tick(10);
      chk("t4_pend", exp_q.size(), 0);
      chk("t4_trig_cnt", trig_cnt_o, 3);
      chk("t4_drop_cnt", drop_cnt_o, 0);

      // busy drop, then a drop coinciding with a clear
      reg_div = 8'd1;
      busy_i = 1'b1;
      pulse(5, 0);
      tick(10);
      chk("t5_drop_cnt", drop_cnt_o, 1);
      chk("t5_trig_cnt", trig_cnt_o, 3);
      trig_ext_i = 1'b1;
      tick(3);
      reg_cnt_clr = 1'b1;
      tick(1);
      reg_cnt_clr = 1'b0;
      tick(3);
      trig_ext_i = 1'b0;
      tick(10);
      busy_i = 1'b0;
      chk("t5_clr_drop", drop_cnt_o, 0);
      chk("t5_clr_trig", trig_cnt_o, 0);

      // reset mid-operation, line held active across release
      reg_filter_width = 16'd2;
      reg_delay = 32'd20;
      trig_ext_i = 1'b1;
      tick(DLY ? 8 : 3);
      rst_i = 1'b1;
      tick(2);
      chk("t6_rst_trigger", trigger_o, 0);
      chk("t6_rst_busy", busy_o, 0);
      chk("t6_rst_trig_cnt", trig_cnt_o, 0);
      chk("t6_rst_drop_cnt", drop_cnt_o, 0);
      rst_i = 1'b0;
      push_exp();
      tick(80);
      chk("t6_pend", exp_q.size(), 0);
      chk("t6_trig_cnt", trig_cnt_o, 1);
      trig_ext_i = 1'b0;
      tick(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
